// File: rtl/cluster_pkg.sv
// Shared types and constants for the PE-cluster load sequencer and its tag/data stream generators.
package cluster_pkg;

    localparam int DATA_SIZE     = 8;
    localparam int ID_SIZE       = 8;
    localparam int ADDR_SIZE     = 16;
    localparam int TAG_ADDR_SIZE = 8;
    localparam int CNT_SIZE      = 8;

    typedef struct packed {
        logic [ID_SIZE-1:0] y;
        logic [ID_SIZE-1:0] x;
    } mcn_tag_t;

    // All-ones coordinates address no PE, so an idle cycle can never be mistaken for a delivery.
    localparam mcn_tag_t TAG_NONE = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_LOAD    = 3'd1,
        ST_A_LOAD    = 3'd2,
        ST_GAP       = 3'd3,
        ST_START     = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_FIN       = 3'd6
    } load_state_t;

    typedef enum logic [0:0] {
        SG_IDLE  = 1'b0,
        SG_BURST = 1'b1
    } stream_state_t;

    function automatic logic is_empty_job(input logic [TAG_ADDR_SIZE-1:0] num_tags,
                                          input logic [CNT_SIZE-1:0]      count);
        return (num_tags == {TAG_ADDR_SIZE{1'b0}}) || (count == {CNT_SIZE{1'b0}});
    endfunction

endpackage

// File: rtl/tag_stream_gen.sv
// Replays one tag-order list and streams count words per tag from a sync-read data memory,
// delivering each word together with its multicast tag on registered outputs.
module tag_stream_gen
    import cluster_pkg::*;
(
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     start,
    input  logic [TAG_ADDR_SIZE-1:0] num_tags,
    input  logic [CNT_SIZE-1:0]      count,
    output logic [TAG_ADDR_SIZE-1:0] tag_addr,
    input  logic [2*ID_SIZE-1:0]     tag_rdata,
    output logic [ADDR_SIZE-1:0]     mem_addr,
    input  logic [DATA_SIZE-1:0]     mem_rdata,
    output logic [DATA_SIZE-1:0]     data,
    output mcn_tag_t                 tag,
    output logic                     done
);

    stream_state_t            state_r, state_next;
    logic [TAG_ADDR_SIZE-1:0] tag_idx_r, num_tags_r;
    logic [CNT_SIZE-1:0]      word_cnt_r, count_r;
    logic [ADDR_SIZE-1:0]     ptr_r;
    logic                     s1_valid_r, s1_last_r;
    logic [DATA_SIZE-1:0]     data_r;
    mcn_tag_t                 tag_r;
    logic                     done_r;
    logic                     launch_s, issue_s, last_word_s, last_tag_s;

    // Next-state and issue decode; the tag address stays on the entry being streamed, so the tag
    // memory returns the matching tag in the same cycle as each data word.
    always_comb begin
        state_next  = state_r;
        launch_s    = 1'b0;
        issue_s     = 1'b0;
        last_word_s = (word_cnt_r == (count_r - CNT_SIZE'(1)));
        last_tag_s  = (tag_idx_r == (num_tags_r - TAG_ADDR_SIZE'(1)));
        case (state_r)
            SG_IDLE: begin
                launch_s = start;
                if (start && !is_empty_job(num_tags, count)) begin
                    state_next = SG_BURST;
                end else begin
                    state_next = SG_IDLE;
                end
            end
            SG_BURST: begin
                issue_s = 1'b1;
                if (last_word_s && last_tag_s) begin
                    state_next = SG_IDLE;
                end else begin
                    state_next = SG_BURST;
                end
            end
            default: state_next = SG_IDLE;
        endcase
    end

    // State, tag index, per-tag word counter and job-wide data pointer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= SG_IDLE;
            tag_idx_r  <= {TAG_ADDR_SIZE{1'b0}};
            num_tags_r <= {TAG_ADDR_SIZE{1'b0}};
            word_cnt_r <= {CNT_SIZE{1'b0}};
            count_r    <= {CNT_SIZE{1'b0}};
            ptr_r      <= {ADDR_SIZE{1'b0}};
        end else begin
            state_r <= state_next;
            if (launch_s) begin
                num_tags_r <= num_tags;
                count_r    <= count;
                tag_idx_r  <= {TAG_ADDR_SIZE{1'b0}};
                word_cnt_r <= {CNT_SIZE{1'b0}};
                ptr_r      <= {ADDR_SIZE{1'b0}};
            end else if (issue_s) begin
                ptr_r <= ptr_r + ADDR_SIZE'(1);
                if (last_word_s) begin
                    word_cnt_r <= {CNT_SIZE{1'b0}};
                    if (!last_tag_s) begin
                        tag_idx_r <= tag_idx_r + TAG_ADDR_SIZE'(1);
                    end
                end else begin
                    word_cnt_r <= word_cnt_r + CNT_SIZE'(1);
                end
            end
        end
    end

    // Read-latency pipeline and registered word/tag outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            data_r     <= {DATA_SIZE{1'b0}};
            tag_r      <= TAG_NONE;
            done_r     <= 1'b0;
        end else begin
            s1_valid_r <= issue_s;
            s1_last_r  <= issue_s && last_word_s && last_tag_s;
            data_r     <= s1_valid_r ? mem_rdata : {DATA_SIZE{1'b0}};
            tag_r      <= s1_valid_r ? mcn_tag_t'(tag_rdata) : TAG_NONE;
            done_r     <= (s1_valid_r && s1_last_r) || (launch_s && is_empty_job(num_tags, count));
        end
    end

    assign tag_addr = tag_idx_r;
    assign mem_addr = ptr_r;
    assign data     = data_r;
    assign tag      = tag_r;
    assign done     = done_r;

endmodule

// File: rtl/cluster_load_ctrl.sv
// Load/config sequencer in front of PE_cluster: streams weights then activations with multicast
// tags, pulses start_compute_o and waits for the cluster to report completion.
module cluster_load_ctrl
    import cluster_pkg::*;
(
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     start_i,
    input  logic [TAG_ADDR_SIZE-1:0] num_w_tags_i,
    input  logic [TAG_ADDR_SIZE-1:0] num_a_tags_i,
    input  logic [CNT_SIZE-1:0]      wcount_i,
    input  logic [CNT_SIZE-1:0]      acount_i,
    output logic [TAG_ADDR_SIZE-1:0] wtag_addr_o,
    input  logic [2*ID_SIZE-1:0]     wtag_rdata_i,
    output logic [TAG_ADDR_SIZE-1:0] atag_addr_o,
    input  logic [2*ID_SIZE-1:0]     atag_rdata_i,
    output logic [ADDR_SIZE-1:0]     wmem_addr_o,
    input  logic [DATA_SIZE-1:0]     wmem_rdata_i,
    output logic [ADDR_SIZE-1:0]     amem_addr_o,
    input  logic [DATA_SIZE-1:0]     amem_rdata_i,
    output logic [DATA_SIZE-1:0]     w_data_o,
    output logic [ID_SIZE-1:0]       weight_tag_x_o,
    output logic [ID_SIZE-1:0]       weight_tag_y_o,
    output logic [DATA_SIZE-1:0]     a_data_o,
    output logic [ID_SIZE-1:0]       act_tag_x_o,
    output logic [ID_SIZE-1:0]       act_tag_y_o,
    output logic                     start_compute_o,
    input  logic                     cluster_done_i,
    output logic                     busy_o,
    output logic                     done_o
);

    load_state_t              state_r, state_next;
    logic [TAG_ADDR_SIZE-1:0] num_a_tags_r;
    logic [CNT_SIZE-1:0]      acount_r;
    logic                     w_start_s, a_start_s, w_done_s, a_done_s;
    logic                     start_compute_nxt_s, done_nxt_s, busy_nxt_s;
    logic                     start_compute_r, done_r, busy_r;
    mcn_tag_t                 w_tag_s, a_tag_s;

    tag_stream_gen u_w_stream (
        .clk       (clk),
        .nrst      (nrst),
        .start     (w_start_s),
        .num_tags  (num_w_tags_i),
        .count     (wcount_i),
        .tag_addr  (wtag_addr_o),
        .tag_rdata (wtag_rdata_i),
        .mem_addr  (wmem_addr_o),
        .mem_rdata (wmem_rdata_i),
        .data      (w_data_o),
        .tag       (w_tag_s),
        .done      (w_done_s)
    );

    tag_stream_gen u_a_stream (
        .clk       (clk),
        .nrst      (nrst),
        .start     (a_start_s),
        .num_tags  (num_a_tags_r),
        .count     (acount_r),
        .tag_addr  (atag_addr_o),
        .tag_rdata (atag_rdata_i),
        .mem_addr  (amem_addr_o),
        .mem_rdata (amem_rdata_i),
        .data      (a_data_o),
        .tag       (a_tag_s),
        .done      (a_done_s)
    );

    // Job sequencing; each stream's done pulse coincides with its last word on the outputs.
    always_comb begin
        state_next          = state_r;
        w_start_s           = 1'b0;
        a_start_s           = 1'b0;
        start_compute_nxt_s = 1'b0;
        done_nxt_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_W_LOAD;
                    w_start_s  = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_W_LOAD: begin
                if (w_done_s) begin
                    state_next = ST_A_LOAD;
                    a_start_s  = 1'b1;
                end else begin
                    state_next = ST_W_LOAD;
                end
            end
            ST_A_LOAD: begin
                if (a_done_s) begin
                    state_next = ST_GAP;
                end else begin
                    state_next = ST_A_LOAD;
                end
            end
            ST_GAP: begin
                state_next          = ST_START;
                start_compute_nxt_s = 1'b1;
            end
            ST_START: state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (cluster_done_i) begin
                    state_next = ST_FIN;
                    done_nxt_s = 1'b1;
                end else begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        busy_nxt_s = (state_next != ST_IDLE);
    end

    // State register, registered control outputs and the act-phase job parameters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r         <= ST_IDLE;
            start_compute_r <= 1'b0;
            done_r          <= 1'b0;
            busy_r          <= 1'b0;
            num_a_tags_r    <= {TAG_ADDR_SIZE{1'b0}};
            acount_r        <= {CNT_SIZE{1'b0}};
        end else begin
            state_r         <= state_next;
            start_compute_r <= start_compute_nxt_s;
            done_r          <= done_nxt_s;
            busy_r          <= busy_nxt_s;
            if (w_start_s) begin
                num_a_tags_r <= num_a_tags_i;
                acount_r     <= acount_i;
            end
        end
    end

    assign weight_tag_x_o  = w_tag_s.x;
    assign weight_tag_y_o  = w_tag_s.y;
    assign act_tag_x_o     = a_tag_s.x;
    assign act_tag_y_o     = a_tag_s.y;
    assign start_compute_o = start_compute_r;
    assign done_o          = done_r;
    assign busy_o          = busy_r;

endmodule

// File: tb/tb_cluster_load_ctrl.sv
// Directed bench for cluster_load_ctrl: sync-read memory models, per-cycle output logging and
// hand-derived expectations for streaming order, timing, skip cases and mid-job reset.
module tb_cluster_load_ctrl;
    import cluster_pkg::*;

    logic        clk = 1'b0;
    logic        nrst, start_i, cluster_done_i;
    logic [7:0]  num_w_tags_i, num_a_tags_i, wcount_i, acount_i;
    logic [7:0]  wtag_addr_o, atag_addr_o;
    logic [15:0] wtag_rdata_i, atag_rdata_i;
    logic [15:0] wmem_addr_o, amem_addr_o;
    logic [7:0]  wmem_rdata_i, amem_rdata_i, w_data_o, a_data_o;
    logic [7:0]  weight_tag_x_o, weight_tag_y_o, act_tag_x_o, act_tag_y_o;
    logic        start_compute_o, busy_o, done_o;

    logic [15:0] wtag_mem [0:255];
    logic [15:0] atag_mem [0:255];
    logic [7:0]  wmem [0:65535];
    logic [7:0]  amem [0:65535];

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] w_log[$];
    logic [23:0] a_log[$];
    int          w_cyc[$];
    int          a_cyc[$];
    int          start_hi, start_cyc, done_cyc, cd_cyc, w_dirty, a_dirty;

    cluster_load_ctrl dut (
        .clk(clk), .nrst(nrst), .start_i(start_i),
        .num_w_tags_i(num_w_tags_i), .num_a_tags_i(num_a_tags_i),
        .wcount_i(wcount_i), .acount_i(acount_i),
        .wtag_addr_o(wtag_addr_o), .wtag_rdata_i(wtag_rdata_i),
        .atag_addr_o(atag_addr_o), .atag_rdata_i(atag_rdata_i),
        .wmem_addr_o(wmem_addr_o), .wmem_rdata_i(wmem_rdata_i),
        .amem_addr_o(amem_addr_o), .amem_rdata_i(amem_rdata_i),
        .w_data_o(w_data_o), .weight_tag_x_o(weight_tag_x_o), .weight_tag_y_o(weight_tag_y_o),
        .a_data_o(a_data_o), .act_tag_x_o(act_tag_x_o), .act_tag_y_o(act_tag_y_o),
        .start_compute_o(start_compute_o), .cluster_done_i(cluster_done_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Sync-read memories, one cycle of latency.
    always @(posedge clk) begin
        wtag_rdata_i <= wtag_mem[wtag_addr_o];
        atag_rdata_i <= atag_mem[atag_addr_o];
        wmem_rdata_i <= wmem[wmem_addr_o];
        amem_rdata_i <= amem[amem_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string nm);
        chk({nm, "_w_data"},  32'(w_data_o), 32'h0);
        chk({nm, "_a_data"},  32'(a_data_o), 32'h0);
        chk({nm, "_w_tag"},   32'({weight_tag_y_o, weight_tag_x_o}), 32'hffff);
        chk({nm, "_a_tag"},   32'({act_tag_y_o, act_tag_x_o}), 32'hffff);
        chk({nm, "_tagaddr"}, 32'({wtag_addr_o, atag_addr_o}), 32'h0);
        chk({nm, "_memaddr"}, {wmem_addr_o, amem_addr_o}, 32'h0);
        chk({nm, "_ctrl"},    32'({start_compute_o, done_o, busy_o}), 32'h0);
    endtask

    // Launches a job and logs every driven word until done_o, a mid-A_LOAD reset, or the budget.
    task automatic run_job(input int nw, input int na, input int wc, input int ac,
                           input int inject_cyc, input int abort_after);
        w_log.delete(); a_log.delete(); w_cyc.delete(); a_cyc.delete();
        start_hi = 0; start_cyc = -1; done_cyc = -1; cd_cyc = -1; w_dirty = 0; a_dirty = 0;
        @(negedge clk);
        num_w_tags_i = 8'(nw); num_a_tags_i = 8'(na); wcount_i = 8'(wc); acount_i = 8'(ac);
        start_i = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            start_i = (cyc == inject_cyc);
            if (cyc == inject_cyc) begin
                num_w_tags_i = 8'd5; wcount_i = 8'd7; num_a_tags_i = 8'd1; acount_i = 8'd1;
            end
            cluster_done_i = (cyc == cd_cyc);
            if ({weight_tag_y_o, weight_tag_x_o} != 16'hffff) begin
                w_log.push_back({weight_tag_y_o, weight_tag_x_o, w_data_o});
                w_cyc.push_back(cyc);
            end else if (w_data_o != 8'h00) begin
                w_dirty++;
            end
            if ({act_tag_y_o, act_tag_x_o} != 16'hffff) begin
                a_log.push_back({act_tag_y_o, act_tag_x_o, a_data_o});
                a_cyc.push_back(cyc);
            end else if (a_data_o != 8'h00) begin
                a_dirty++;
            end
            if (start_compute_o) begin
                start_hi++;
                if (start_cyc < 0) begin
                    start_cyc = cyc;
                    cd_cyc    = cyc + 50;
                end
            end
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            if (abort_after > 0 && a_log.size() == abort_after) begin
                nrst = 1'b0;
                #1;
                check_reset_outs("abort");
                for (int k = 0; k < 25; k++) begin
                    @(negedge clk);
                    if (start_compute_o) start_hi++;
                    if (k == 5) nrst = 1'b1;
                end
                chk("abort_no_start", 32'(start_hi), 32'd0);
                chk("abort_idle_busy", 32'(busy_o), 32'd0);
                break;
            end
        end
        cluster_done_i = 1'b0;
    endtask

    task automatic verify_job(input string nm, input int nw, input int na, input int wc, input int ac);
        chk({nm, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        chk({nm, "_w_words"}, 32'(w_log.size()), 32'(nw * wc));
        chk({nm, "_a_words"}, 32'(a_log.size()), 32'(na * ac));
        for (int i = 0; i < w_log.size() && i < nw * wc; i++) begin
            chk($sformatf("%s_w%0d", nm, i), 32'(w_log[i]), {8'h00, wtag_mem[i / wc], wmem[i]});
            if (i > 0) begin
                if (i % wc != 0) chk($sformatf("%s_wgap%0d", nm, i), 32'(w_cyc[i] - w_cyc[i-1]), 32'd1);
                else chk($sformatf("%s_wbetween%0d", nm, i), 32'(w_cyc[i] - w_cyc[i-1] <= 3), 32'd1);
            end
        end
        for (int i = 0; i < a_log.size() && i < na * ac; i++) begin
            chk($sformatf("%s_a%0d", nm, i), 32'(a_log[i]), {8'h00, atag_mem[i / ac], amem[i]});
            if (i > 0) begin
                if (i % ac != 0) chk($sformatf("%s_agap%0d", nm, i), 32'(a_cyc[i] - a_cyc[i-1]), 32'd1);
                else chk($sformatf("%s_abetween%0d", nm, i), 32'(a_cyc[i] - a_cyc[i-1] <= 3), 32'd1);
            end
        end
        chk({nm, "_start_width"}, 32'(start_hi), 32'd1);
        if (a_cyc.size() > 0) chk({nm, "_start_cyc"}, 32'(start_cyc), 32'(a_cyc[a_cyc.size()-1] + 2));
        if (w_cyc.size() > 0) chk({nm, "_w_before_start"}, 32'(start_cyc > w_cyc[w_cyc.size()-1]), 32'd1);
        chk({nm, "_done_cyc"}, 32'(done_cyc), 32'(start_cyc + 51));
        chk({nm, "_idle_data"}, 32'(w_dirty + a_dirty), 32'd0);
        @(negedge clk);
        chk({nm, "_busy_after"}, 32'(busy_o), 32'd0);
        chk({nm, "_done_width"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            wtag_mem[i] = {8'h00, 8'(i)};
            atag_mem[i] = {8'(8'h20 + i), 8'h05};
        end
        for (int i = 0; i < 65536; i++) begin
            wmem[i] = 8'(i);
            amem[i] = 8'(8'h80 + i);
        end
        nrst = 1'b0; start_i = 1'b0; cluster_done_i = 1'b0;
        num_w_tags_i = 8'd0; num_a_tags_i = 8'd0; wcount_i = 8'd0; acount_i = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        nrst = 1'b1;
        @(negedge clk);
        cluster_done_i = 1'b1;
        @(negedge clk);
        cluster_done_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_cluster_done_ignored", 32'({done_o, busy_o, start_compute_o}), 32'h0);

        // One weight tag (0,0) carrying 1,2,3; no acts.
        wmem[0] = 8'd1; wmem[1] = 8'd2; wmem[2] = 8'd3;
        run_job(1, 0, 3, 0, -1, 0);
        verify_job("single", 1, 0, 3, 0);
        chk("single_w1_word", 32'(w_log.size() > 1 ? w_log[1] : 24'h0), 32'h000002);
        for (int i = 0; i < 3; i++) wmem[i] = 8'(i);

        // Three weight tags, pointer continues across tags; act outputs must stay idle.
        run_job(3, 0, 3, 0, -1, 0);
        verify_job("three_w", 3, 0, 3, 0);
        chk("three_w_tag1_first", 32'(w_log.size() > 3 ? w_log[3] : 24'h0), 32'h000103);
        chk("three_w_tag1_last",  32'(w_log.size() > 5 ? w_log[5] : 24'h0), 32'h000105);

        // Full job: 9 weight words then 15 act words, start, then cluster done after 50 cycles.
        run_job(3, 3, 3, 5, -1, 0);
        verify_job("full", 3, 3, 3, 5);
        chk("full_a_last", 32'(a_log.size() > 14 ? a_log[14] : 24'h0), 32'h22058e);

        // A second start_i during W_LOAD with different counts must not disturb the job.
        run_job(3, 3, 3, 5, 3, 0);
        verify_job("inject", 3, 3, 3, 5);

        // Zero word count skips the weight phase entirely.
        run_job(2, 3, 0, 2, -1, 0);
        verify_job("skip_w", 2, 3, 0, 2);

        // Reset during A_LOAD, then a fresh job from tag 0.
        run_job(3, 3, 3, 5, -1, 2);
        run_job(3, 3, 3, 5, -1, 0);
        verify_job("after_reset", 3, 3, 3, 5);
        chk("after_reset_first", 32'(w_log.size() > 0 ? w_log[0] : 24'hffffff), 32'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
